// File: rtl/spi_master_multi_pkg.sv
// Shared types for the multi-slave SPI master: FSM states, latched transfer
// configuration and default widths.
package spi_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_NUM_CS = 4;
  localparam int DEF_DVSR_W = 16;

  // Config fields are sized for the widest supported instance (DVSR_W <= 32).
  localparam int CFG_CS_W   = 8;
  localparam int CFG_DVSR_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    H1,
    H2,
    CS_HOLD
  } spi_state_e;

  typedef struct packed {
    logic                  cpol;
    logic                  cpha;
    logic                  lsb_first;
    logic                  hold_cs;
    logic [CFG_CS_W-1:0]   cs_idx;
    logic [CFG_DVSR_W-1:0] divisor;
  } spi_cfg_t;

  function automatic logic [CFG_DVSR_W-1:0] eff_divisor(input logic [CFG_DVSR_W-1:0] d);
    return (d == '0) ? CFG_DVSR_W'(1) : d;
  endfunction

endpackage

// File: rtl/spi_master_multi_if.sv
// Control-side and pad-side signals of the SPI master, bundled with modports
// for the master block and for whoever drives it.
interface spi_master_multi_if
  import spi_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CS = DEF_NUM_CS,
  parameter int DVSR_W = DEF_DVSR_W
);
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic [DATA_W-1:0] din_i;
  logic [DVSR_W-1:0] dvsr_i;
  logic              cpol_i;
  logic              cpha_i;
  logic              lsb_first_i;
  logic [CS_W-1:0]   cs_sel_i;
  logic              hold_cs_i;
  logic              start_i;
  logic              miso_i;
  logic              ready_o;
  logic [DATA_W-1:0] dout_o;
  logic              spi_done_tick_o;
  logic              sclk_o;
  logic              mosi_o;
  logic [NUM_CS-1:0] ss_n_o;

  modport master (
    input  din_i, dvsr_i, cpol_i, cpha_i, lsb_first_i, cs_sel_i, hold_cs_i,
    input  start_i, miso_i,
    output ready_o, dout_o, spi_done_tick_o, sclk_o, mosi_o, ss_n_o
  );

  modport slave (
    output din_i, dvsr_i, cpol_i, cpha_i, lsb_first_i, cs_sel_i, hold_cs_i,
    output start_i, miso_i,
    input  ready_o, dout_o, spi_done_tick_o, sclk_o, mosi_o, ss_n_o
  );

endinterface

// File: rtl/spi_master_multi_shifter.sv
// Transmit/receive shift registers with selectable bit order. next_bit is the
// bit that will be presented once this cycle's load/shift takes effect.
module spi_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              load,
  input  logic              lsb_first,
  input  logic [DATA_W-1:0] din,
  input  logic              shift,
  input  logic              sample,
  input  logic              sin,
  output logic              next_bit,
  output logic [DATA_W-1:0] rx
);
  logic [DATA_W-1:0] tx;

  always_ff @(posedge clk_i) begin
    if (load) begin
      tx <= din;
    end else if (shift) begin
      tx <= lsb_first ? (tx >> 1) : (tx << 1);
    end
    if (sample) begin
      rx <= lsb_first ? {sin, rx[DATA_W-1:1]} : {rx[DATA_W-2:0], sin};
    end
  end

  always_comb begin
    next_bit = lsb_first ? tx[0] : tx[DATA_W-1];
    if (load) begin
      next_bit = lsb_first ? din[0] : din[DATA_W-1];
    end else if (shift) begin
      next_bit = lsb_first ? tx[1] : tx[DATA_W-2];
    end
  end

endmodule

// File: rtl/spi_master_multi.sv
// SPI master with all CPOL/CPHA modes, selectable bit order, one-hot slave
// selects and CS hold across back-to-back transfers to the same slave.
module spi_master_multi
  import spi_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CS = DEF_NUM_CS,
  parameter int DVSR_W = DEF_DVSR_W
) (
  input logic                clk_i,
  input logic                rst_ni,
  spi_master_multi_if.master bus
);
  localparam int BIT_W = $clog2(DATA_W);

  spi_state_e            state_q, state_d;
  spi_cfg_t              cfg_q, cfg_d;
  logic [CFG_DVSR_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  held_q, held_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic [NUM_CS-1:0]     ss_q, ss_d;
  logic [DATA_W-1:0]     dout_q, dout_d;
  logic                  done_q, done_d;
  logic                  load, shift, sample, next_bit, last_cnt;
  logic [DATA_W-1:0]     rx;
  logic [DVSR_W-1:0]     dvsr_in;
  logic [CFG_CS_W-1:0]   cs_req;

  function automatic logic [NUM_CS-1:0] sel_n(input logic [CFG_CS_W-1:0] idx);
    logic [NUM_CS-1:0] v;
    for (int i = 0; i < NUM_CS; i++) v[i] = (idx != CFG_CS_W'(i));
    return v;
  endfunction

  assign dvsr_in  = bus.dvsr_i;
  assign cs_req   = CFG_CS_W'(32'(bus.cs_sel_i) % 32'(NUM_CS));
  assign last_cnt = (cnt_q == cfg_q.divisor - CFG_DVSR_W'(1));

  spi_shifter #(.DATA_W(DATA_W)) u_shifter (
    .clk_i     (clk_i),
    .load      (load),
    .lsb_first (cfg_d.lsb_first),
    .din       (bus.din_i),
    .shift     (shift),
    .sample    (sample),
    .sin       (bus.miso_i),
    .next_bit  (next_bit),
    .rx        (rx)
  );

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    cnt_d   = cnt_q + CFG_DVSR_W'(1);
    bit_d   = bit_q;
    held_d  = held_q;
    ss_d    = ss_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    sample  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.start_i) begin
          cfg_d.cpol      = bus.cpol_i;
          cfg_d.cpha      = bus.cpha_i;
          cfg_d.lsb_first = bus.lsb_first_i;
          cfg_d.hold_cs   = bus.hold_cs_i;
          cfg_d.cs_idx    = cs_req;
          cfg_d.divisor   = eff_divisor(CFG_DVSR_W'(dvsr_in));
          load            = 1'b1;
          bit_d           = '0;
          held_d          = 1'b0;
          // A held CS for the same slave skips setup and stays asserted.
          if (held_q && cfg_q.cs_idx == cs_req) begin
            state_d = H1;
          end else begin
            ss_d    = sel_n(cs_req);
            state_d = CS_SETUP;
          end
        end
      end
      CS_SETUP: begin
        if (last_cnt) begin
          cnt_d   = '0;
          state_d = H1;
        end
      end
      H1: begin
        if (last_cnt) begin
          cnt_d   = '0;
          sample  = 1'b1;
          state_d = H2;
        end
      end
      H2: begin
        if (last_cnt) begin
          cnt_d = '0;
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            state_d = CS_HOLD;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift   = 1'b1;
            state_d = H1;
          end
        end
      end
      CS_HOLD: begin
        if (last_cnt) begin
          cnt_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
          dout_d  = rx;
          if (cfg_q.hold_cs) held_d = 1'b1;
          else               ss_d   = '1;
        end
      end
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      IDLE:    sclk_d = bus.cpol_i;
      H1:      sclk_d = cfg_d.cpol ^ cfg_d.cpha;
      H2:      sclk_d = ~(cfg_d.cpol ^ cfg_d.cpha);
      default: sclk_d = cfg_d.cpol;
    endcase
    mosi_d = (state_d == IDLE) ? 1'b0 : next_bit;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      held_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ss_q    <= '1;
      dout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      held_q  <= held_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ss_q    <= ss_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready_o         = (state_q == IDLE);
  assign bus.dout_o          = dout_q;
  assign bus.spi_done_tick_o = done_q;
  assign bus.sclk_o          = sclk_q;
  assign bus.mosi_o          = mosi_q;
  assign bus.ss_n_o          = ss_q;

endmodule
